// File: rtl/nonresdiv_seq.sv
// Sequential non-restoring divider, signed or unsigned, one quotient bit per cycle.
// Z carries {remainder, quotient}; dbz flags a zero divisor.
module nonresdiv_seq #(
    parameter int WIDTH          = 32,
    parameter int SIGNED_DEFAULT = 1
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, dvd, dvs;
    logic             mode_q, qneg, rneg;
    logic             asgn, bsgn;
    logic [WIDTH:0]   rem, shifted, stepped;
    logic [WIDTH-1:0] amag, bmag, fixed, qfin, rfin;

    assign asgn = mode_q & a_q[WIDTH-1];
    assign bsgn = mode_q & b_q[WIDTH-1];
    assign amag = asgn ? -a_q : a_q;
    assign bmag = bsgn ? -b_q : b_q;

    // dvd shifts dividend bits out at the top and quotient bits in at the bottom
    assign shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign stepped = rem[WIDTH] ? shifted + {1'b0, dvs}
                                : shifted - {1'b0, dvs};

    assign fixed = rem[WIDTH-1:0] + (rem[WIDTH] ? dvs : '0);
    assign qfin  = qneg ? -dvd : dvd;
    assign rfin  = rneg ? -fixed : fixed;

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PREP;
            PREP:    state_nx = (b_q == '0) ? DONE : ITER;
            ITER:    if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= (SIGNED_DEFAULT != 0);
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            Z      <= '0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        mode_q <= mode;
                    end
                end
                PREP: begin
                    if (b_q == '0) begin
                        Z   <= '0;
                        dbz <= 1'b1;
                    end else begin
                        dvd  <= amag;
                        dvs  <= bmag;
                        qneg <= asgn ^ bsgn;
                        rneg <= asgn;
                        rem  <= '0;
                        cnt  <= CW'(WIDTH);
                    end
                end
                ITER: begin
                    rem <= stepped;
                    dvd <= {dvd[WIDTH-2:0], ~stepped[WIDTH]};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    Z   <= {rfin, qfin};
                    dbz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonresdiv_seq.sv
// Bench for nonresdiv_seq: 32-bit directed cases and an 8-bit random sweep,
// checked through per-instance scoreboards against a truncating-division model.
module tb_nonresdiv_seq;

    typedef struct {
        logic [127:0] z;
        bit           dbz;
        int           lat;
        int           t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        start32, mode32, busy32, done32, dbz32;
    logic [31:0] a32, b32;
    logic [63:0] z32;
    logic        start8, mode8, busy8, done8, dbz8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nonresdiv_seq #(.WIDTH(32), .SIGNED_DEFAULT(1)) dut32 (
        .clock(clk), .clear_n(clear_n), .start(start32), .mode(mode32),
        .A(a32), .B(b32), .busy(busy32), .done(done32), .dbz(dbz32), .Z(z32)
    );

    nonresdiv_seq #(.WIDTH(8), .SIGNED_DEFAULT(1)) dut8 (
        .clock(clk), .clear_n(clear_n), .start(start8), .mode(mode8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .dbz(dbz8), .Z(z8)
    );

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Truncating division in plain integer arithmetic
    function automatic exp_t model(int w, bit m, longint unsigned a,
                                   longint unsigned b);
        exp_t            e;
        longint unsigned mask, qu, ru;
        longint          sa, sb;
        mask  = (64'd1 << w) - 64'd1;
        a     = a & mask;
        b     = b & mask;
        e.z   = '0;
        e.dbz = 1'b0;
        e.t0  = 0;
        if (b == 0) begin
            e.dbz = 1'b1;
            e.lat = 2;
            return e;
        end
        e.lat = w + 3;
        if (m) begin
            sa = a[w-1] ? $signed(a) - $signed(64'd1 << w) : $signed(a);
            sb = b[w-1] ? $signed(b) - $signed(64'd1 << w) : $signed(b);
            qu = $unsigned(sa / sb) & mask;
            ru = $unsigned(sa % sb) & mask;
        end else begin
            qu = a / b;
            ru = a % b;
        end
        e.z = (128'(ru) << w) | 128'(qu);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                check("d32_spurious_done", 128'(done32), 128'(0));
            end else begin
                e32 = q32.pop_front();
                check("d32_z", 128'(z32), e32.z);
                check("d32_dbz", 128'(dbz32), 128'(e32.dbz));
                check("d32_latency", 128'(cyc - e32.t0), 128'(e32.lat));
                check("d32_busy_at_done", 128'(busy32), 128'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("d8_spurious_done", 128'(done8), 128'(0));
            end else begin
                e8 = q8.pop_front();
                check("d8_z", 128'(z8), e8.z);
                check("d8_dbz", 128'(dbz8), 128'(e8.dbz));
                check("d8_latency", 128'(cyc - e8.t0), 128'(e8.lat));
            end
        end
    end

    task automatic issue32(bit m, logic [31:0] a, logic [31:0] b);
        exp_t e;
        @(negedge clk);
        start32 = 1'b1;
        mode32  = m;
        a32     = a;
        b32     = b;
        e       = model(32, m, 64'(a), 64'(b));
        e.t0    = cyc + 1;
        q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
        a32     = $urandom;
        b32     = $urandom;
        mode32  = 1'($urandom);
    endtask

    task automatic wait_idle32();
        int k = 0;
        while (busy32 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("d32_timeout", 128'(busy32), 128'(0));
    endtask

    task automatic issue8(bit m, logic [7:0] a, logic [7:0] b);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1;
        mode8  = m;
        a8     = a;
        b8     = b;
        e      = model(8, m, 64'(a), 64'(b));
        e.t0   = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        mode8  = 1'($urandom);
        begin
            int k = 0;
            while (busy8 && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) check("d8_timeout", 128'(busy8), 128'(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        clear_n = 1'b0;
        start32 = 1'b1;
        mode32  = 1'b1;
        a32     = 32'd5;
        b32     = 32'd1;
        start8  = 1'b1;
        mode8   = 1'b0;
        a8      = 8'd3;
        b8      = 8'd1;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy32), 128'(0));
        check("rst_done", 128'(done32), 128'(0));
        check("rst_dbz", 128'(dbz32), 128'(0));
        check("rst_z", 128'(z32), 128'(0));
        check("rst_busy8", 128'(busy8), 128'(0));
        clear_n = 1'b1;
        start32 = 1'b0;
        start8  = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 128'(busy32), 128'(0));

        issue32(1'b1, 32'd100, 32'd7);
        wait_idle32();
        check("q_100_7", 128'(z32[31:0]), 128'(14));
        check("r_100_7", 128'(z32[63:32]), 128'(2));
        issue32(1'b1, -32'sd100, 32'd7);
        wait_idle32();
        check("q_m100_7", 128'(z32[31:0]), 128'(32'hFFFF_FFF2));
        check("r_m100_7", 128'(z32[63:32]), 128'(32'hFFFF_FFFE));
        issue32(1'b1, 32'd100, -32'sd7);
        wait_idle32();
        issue32(1'b0, 32'hFFFF_FFFF, 32'd2);
        wait_idle32();
        check("q_u_ff_2", 128'(z32[31:0]), 128'(32'h7FFF_FFFF));
        issue32(1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_idle32();
        issue32(1'b1, 32'd1234, 32'd0);
        wait_idle32();
        check("dbz_flag", 128'(dbz32), 128'(1));
        issue32(1'b1, 32'd9, 32'd3);
        wait_idle32();
        check("q_9_3", 128'(z32[31:0]), 128'(3));
        issue32(1'b0, 32'hDEAD_BEEF, 32'd0);
        wait_idle32();

        // Overflow case, with a stray start in the middle of the operation
        issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        start32 = 1'b1;
        a32     = 32'd77;
        b32     = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        wait_idle32();
        check("q_ovf", 128'(z32[31:0]), 128'(32'h8000_0000));
        repeat (45) @(negedge clk);
        check("stray_start_busy", 128'(busy32), 128'(0));

        // start held high: two back-to-back operations
        @(negedge clk);
        start32 = 1'b1;
        mode32  = 1'b0;
        a32     = 32'd1000;
        b32     = 32'd33;
        e       = model(32, 1'b0, 64'd1000, 64'd33);
        e.t0    = cyc + 1;
        q32.push_back(e);
        e.t0    = e.t0 + 36;
        q32.push_back(e);
        repeat (40) @(negedge clk);
        start32 = 1'b0;
        wait_idle32();
        repeat (3) @(negedge clk);
        check("b2b_drained", 128'(q32.size()), 128'(0));

        // Reset in the middle of ITER, with start asserted alongside it
        issue32(1'b1, 32'd5000, 32'd3);
        repeat (6) @(negedge clk);
        clear_n = 1'b0;
        start32 = 1'b1;
        @(negedge clk);
        clear_n = 1'b1;
        start32 = 1'b0;
        q32.delete();
        check("abort_busy", 128'(busy32), 128'(0));
        check("abort_z", 128'(z32), 128'(0));
        check("abort_dbz", 128'(dbz32), 128'(0));
        repeat (45) @(negedge clk);
        check("abort_no_restart", 128'(busy32), 128'(0));

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 10 == 3) rb = 32'd0;
            issue32(1'($urandom), ra, rb);
            wait_idle32();
        end

        issue8(1'b1, 8'h80, 8'hFF);
        issue8(1'b0, 8'hFF, 8'h01);
        issue8(1'b1, 8'h7F, 8'h80);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 25 == 0) rb = 8'd0;
            issue8(1'($urandom), ra, rb);
        end

        repeat (50) @(negedge clk);
        check("q32_empty", 128'(q32.size()), 128'(0));
        check("q8_empty", 128'(q8.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nonresdiv_seq.md
NONRESDIV_SEQ -- requirements
Module: nonresdiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter SIGNED_DEFAULT, default 1, meaning the value of mode used when mode is tied off at integration.
REQ-003 Port clock, input, 1, sole clock; all state changes on the rising edge.
REQ-004 Port clear_n, input, 1, reset; synchronous, active-low.
REQ-005 Port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-006 Port mode, input, 1, 1 = signed two's-complement divide, 0 = unsigned divide; sampled with start.
REQ-007 Port A, input, WIDTH, dividend; sampled with start.
REQ-008 Port B, input, WIDTH, divisor; sampled with start.
REQ-009 Port busy, output, 1, high from the edge after start is accepted until done asserts.
REQ-010 Port done, output, 1, single-cycle pulse marking Z and dbz valid.
REQ-011 Port dbz, output, 1, divide-by-zero flag for the result presented with done.
REQ-012 Port Z, output, 2*WIDTH, result: remainder in Z[2*WIDTH-1:WIDTH] (HI), quotient in Z[WIDTH-1:0] (LO).

Function
REQ-013 The block SHALL implement a registered FSM with states IDLE, PREP, ITER, FIX, DONE.
REQ-014 IDLE: start=1 SHALL latch A, B and mode and move to PREP; start=0 SHALL stay in IDLE.
REQ-015 PREP: if latched B==0, the FSM SHALL go directly to DONE with Z=0 and dbz=1; otherwise it SHALL form operand magnitudes (mode=1) or raw values (mode=0), record the quotient and remainder signs, load the iteration counter with WIDTH, and go to ITER.
REQ-016 ITER SHALL perform one non-restoring step per cycle: remainder shifts left by 1, bringing in the next dividend bit, MSB first; the divisor is subtracted if the partial remainder is >= 0 and added if it is < 0; the quotient bit is 1 if the new remainder is >= 0, else 0.
REQ-017 The partial remainder register SHALL be WIDTH+1 bits wide so that no step overflows for any unsigned WIDTH-bit operand.
REQ-018 After exactly WIDTH ITER cycles the FSM SHALL go to FIX.
REQ-019 FIX SHALL add the divisor once if the partial remainder is negative; it SHALL then negate the quotient if the operand signs differ (mode=1), negate the remainder if the dividend was negative (mode=1), and go to DONE.
REQ-020 Results SHALL equal truncating division: quotient rounded toward zero, remainder sign equal to dividend sign, and A = Q*B + R for every B != 0.
REQ-021 Signed overflow (A = most-negative, B = -1, mode=1) SHALL give quotient = most-negative (wrap) and remainder 0, with dbz=0.
REQ-022 DONE SHALL drive done=1 and busy=0 for one cycle, update Z and dbz on entry, and return to IDLE.
REQ-023 Latency: with B != 0, done SHALL be high in the cycle following the (WIDTH+3)th rising edge after the edge that sampled start; with B==0 it SHALL follow the 2nd such edge.
REQ-024 start SHALL be ignored in every state other than IDLE; an operation in flight SHALL NOT be disturbed.
REQ-025 start held high continuously SHALL begin a new operation on the IDLE cycle after each done (back-to-back throughput of one result per WIDTH+4 cycles).
REQ-026 Changes on A, B or mode after the sampling edge SHALL NOT affect the result.
REQ-027 Z and dbz SHALL hold their last value until the next DONE entry or reset.

Reset
REQ-028 clear_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, dbz=0, Z=0, and clear the counter and internal registers, regardless of state.
REQ-029 Reset mid-operation SHALL abort that operation with no done pulse; start sampled in the same cycle as clear_n=0 SHALL be ignored.

Verification
REQ-030 WIDTH=32, mode=1, A=100, B=7, start one cycle -> done exactly 35 edges later; Z[31:0]=14, Z[63:32]=2, dbz=0.
REQ-031 WIDTH=32, mode=1, A=-100, B=7 -> Q=-14 (0xFFFFFFF2), R=-2 (0xFFFFFFFE); A=100, B=-7 -> Q=-14, R=2.
REQ-032 WIDTH=32, mode=0, A=0xFFFFFFFF, B=2 -> Q=0x7FFFFFFF, R=1; mode=1 with the same operands -> Q=0, R=-1.
REQ-033 WIDTH=32, B=0, any A -> done 2 edges after the start edge, Z=0, dbz=1; next op A=9, B=3 -> Q=3, R=0, dbz=0.
REQ-034 WIDTH=32, mode=1, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0; then start pulsed at cycle 10 of a busy op -> ignored, one done only.
REQ-035 clear_n=0 pulsed at ITER cycle 5 -> no done, busy=0, Z=0; WIDTH=8 random sweep against a reference model -> all results match REQ-020.
